pooling_ctrl: RTL
=================

# pooling_ctrl

Control sequencer for the 2x2/stride-2 pooling stage that sits after the systolic array. It counts the row-major pixel stream arriving with `in_valid` and drives the pooling datapath: the x-input mux, pooling enable, and register-file read/write addresses and write source. It flags each completed pooled pixel and signals the end of a feature map. Max/avg selection and arithmetic stay in the datapath; this block only sequences.

## Interface

Parameters:
- `MAX_W`, 32: maximum feature-map width in pixels; even, power of two.
- `MAX_H`, 32: maximum feature-map height in pixels; even.
- `ADDR_W`, $clog2(MAX_W/2): register-file address width, covering one entry per window column.
- `CW`, $clog2(MAX_W+1): width of the column and width counters.
- `RW`, $clog2(MAX_H+1): width of the row and height counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `nrst` in 1: synchronous, active-low reset.
- `start` in 1: begin a new feature map; the cfg values are latched on this cycle.
- `cfg_width` in CW: map width; must be even, at least 2 and at most MAX_W.
- `cfg_height` in RW: map height; must be even, at least 2 and at most MAX_H.
- `in_valid` in 1: `sys_out` carries a valid pixel this cycle.
- `sel_sys` out 1: 1 selects `sys_out` onto the pooling in1 port; 0 selects the `out` feedback.
- `pool_en` out 1: pooling unit enable.
- `rf_wr` out 1: register-file write enable.
- `rf_wr_sel` out 1: write source; 0 = `sys_out`, 1 = pooled `out`.
- `rf_rd_addr` out ADDR_W: register-file read address.
- `rf_wr_addr` out ADDR_W: register-file write address.
- `out_valid` out 1: pooled `out` is final this cycle.
- `out_row` out RW-1: pooled-pixel row index.
- `out_col` out ADDR_W: pooled-pixel column index.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at end of map.
- `cfg_err` out 1: one-cycle pulse when a configuration is rejected.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, on `start`:
  - Valid cfg: latch W and H, clear `col` and `row`, go to RUN.
  - Invalid cfg (odd, zero or over maximum): pulse `cfg_err` on the next cycle and stay in IDLE.
- RUN, current pixel (`row`, `col`), window index k = `col`>>1:
  - `rf_rd_addr` = `rf_wr_addr` = k at all times.
  - `out_row` = `row`>>1 and `out_col` = k at all times.
- RUN with `in_valid`=1, outputs per window position:
  - Even row, even col (first element): `sel_sys`=1, `pool_en`=0, `rf_wr`=1, `rf_wr_sel`=0. Seeds the register-file entry.
  - Odd row, odd col (last element): `sel_sys`=1, `pool_en`=1, `rf_wr`=0, `out_valid`=1.
  - Other two positions: `sel_sys`=1, `pool_en`=1, `rf_wr`=1, `rf_wr_sel`=1. Accumulates into entry k.
- Counter advance: each accepted pixel increments `col`. At `col`=W-1, `col` wraps to 0 and `row` increments.
- RUN with `in_valid`=0: all strobes are 0 and the counters hold.
- Last pixel (`row`=H-1, `col`=W-1) accepted: go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` while in RUN or DONE is ignored.
- `in_valid` while in IDLE is ignored and no strobes are asserted.

## Timing

- Strobes and addresses are combinational from the registered counters and `in_valid`, so they apply in the same cycle as `sys_out`. The datapath is combinational, so `out_valid` coincides with the final pixel.
- Start-up: `start` at cycle t gives `busy`=1 at t+1. The first pixel is accepted at t+1 at the earliest.
- End of map: last pixel accepted at cycle n gives `done`=1 at n+1 and `busy`=0 at n+1. A new `start` is accepted from n+2.
- `cfg_err` pulses at t+1 for a rejected `start` at t.
- Reset: `nrst`=0 at an edge forces IDLE and zeroes all counters and outputs, including mid-map. Register-file contents are not cleared. `sel_sys` resets to 0.
- Outside RUN, all outputs are 0.
- Throughput: one pixel per cycle, back-to-back `in_valid` supported.

## Test plan

- 4x4 map, `in_valid` continuous: `out_valid` at pixels 5, 7, 13, 15 with (out_row, out_col) = (0,0), (0,1), (1,0), (1,1). `rf_wr_sel`=0 on pixels 0, 2, 8, 10. `done` one cycle after pixel 15.
- 4x4 map, `in_valid` toggling 1/0: same outputs as above, stretched; no strobe is asserted on any idle cycle.
- cfg_width=3, cfg_width=0, or cfg_height=34 (with MAX_H=32): `cfg_err` pulse, `busy` stays 0.
- 32x2 map: `rf_wr_addr` runs 0..15. `col` wraps to 0 with `row`=1 after pixel 31. 16 `out_valid` pulses in total.
- `nrst`=0 after pixel 6 of a 4x4 map: next cycle IDLE with all outputs 0. A fresh `start` then replays the first scenario exactly.
- `start` pulsed during RUN: ignored, and the counters continue unchanged.

Source files
------------

// File: rtl/pooling_ctrl.sv
// Sequencer for the 2x2 / stride-2 pooling stage: counts the row-major pixel stream and drives
// mux select, pooling enable, register-file addresses/write source, and pooled-pixel flags.
// Strobes are combinational from registered counters and in_valid; done/cfg_err are registered pulses.
module pooling_ctrl #(
  parameter int MAX_W  = 32,
  parameter int MAX_H  = 32,
  parameter int ADDR_W = $clog2(MAX_W/2),
  parameter int CW     = $clog2(MAX_W+1),
  parameter int RW     = $clog2(MAX_H+1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [CW-1:0]     cfg_width,
  input  logic [RW-1:0]     cfg_height,
  input  logic              in_valid,
  output logic              sel_sys,
  output logic              pool_en,
  output logic              rf_wr,
  output logic              rf_wr_sel,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic              out_valid,
  output logic [RW-2:0]     out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] MAX_W_C = CW'(MAX_W);
  localparam logic [RW-1:0] MAX_H_C = RW'(MAX_H);

  state_t        state;
  logic [CW-1:0] col;
  logic [CW-1:0] w_last;
  logic [RW-1:0] row;
  logic [RW-1:0] h_last;

  logic cfg_ok;
  logic end_row;
  logic end_map;
  logic first_px;
  logic last_px;

  // Even and non-zero implies at least 2, so only the upper bound needs an explicit check.
  assign cfg_ok = !cfg_width[0]  && (cfg_width  != '0) && (cfg_width  <= MAX_W_C) &&
                  !cfg_height[0] && (cfg_height != '0) && (cfg_height <= MAX_H_C);

  assign end_row  = (col == w_last);
  assign end_map  = end_row && (row == h_last);
  // Window position: top-left seeds the entry, bottom-right completes the pooled pixel.
  assign first_px = !row[0] && !col[0];
  assign last_px  =  row[0] &&  col[0];

  assign busy = (state == RUN);

  // FSM and pixel counters; done/cfg_err are single-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      w_last  <= '0;
      h_last  <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_last <= cfg_width - CW'(1);
              h_last <= cfg_height - RW'(1);
              col    <= '0;
              row    <= '0;
              state  <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            if (end_row) begin
              col <= '0;
              if (end_map) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls: addresses track the window column during RUN, strobes only on accepted pixels.
  always_comb begin
    sel_sys    = 1'b0;
    pool_en    = 1'b0;
    rf_wr      = 1'b0;
    rf_wr_sel  = 1'b0;
    out_valid  = 1'b0;
    rf_rd_addr = '0;
    rf_wr_addr = '0;
    out_row    = '0;
    out_col    = '0;
    if (state == RUN) begin
      rf_rd_addr = col[ADDR_W:1];
      rf_wr_addr = col[ADDR_W:1];
      out_col    = col[ADDR_W:1];
      out_row    = row[RW-1:1];
      if (in_valid) begin
        sel_sys   = 1'b1;
        pool_en   = !first_px;
        rf_wr     = !last_px;
        rf_wr_sel = !first_px && !last_px;
        out_valid = last_px;
      end
    end
  end

endmodule
